score_keeper: RTL and testbench

- Game-level scoring stage sitting directly upstream of the two score digit renderers.
- Consumes ball-out-of-bounds indications from the ball/physics logic and maintains one 4-bit score per player.
- Sequences a post-goal serve pause and ends the match at a fixed point limit.
- Its score_l/score_r outputs drive the `score` inputs of the left and right digit renderers. serve/game_over feed the ball logic and overlay logic.

---
 rtl/score_keeper_if.sv | 24 ++
 rtl/score_keeper.sv | 160 ++++++++++++++++
 tb/tb_score_keeper.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/score_keeper_if.sv
// rtl/score_keeper_if.sv - score_keeper game-event and score/serve signal bundle
interface score_keeper_if;
    logic       frame_tick;
    logic       ball_out_left;
    logic       ball_out_right;
    logic       start;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       serve;
    logic       serve_dir;
    logic       ball_hold;
    logic       game_over;
    logic       winner;

    modport master (
        output frame_tick, ball_out_left, ball_out_right, start,
        input  score_l, score_r, serve, serve_dir, ball_hold, game_over, winner
    );

    modport slave (
        input  frame_tick, ball_out_left, ball_out_right, start,
        output score_l, score_r, serve, serve_dir, ball_hold, game_over, winner
    );
endinterface

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - per-player scoring, post-goal serve pause and match end
module score_keeper #(
    parameter int WIN_SCORE    = 9,
    parameter int PAUSE_FRAMES = 60,
    parameter int FRAME_W      = 6
) (
    input  logic          clock,
    input  logic          reset_n,
    score_keeper_if.slave sk
);
    typedef enum logic [1:0] {IDLE, PLAY, PAUSE, GAME_OVER} state_t;

    localparam logic [3:0]         WIN4       = 4'(WIN_SCORE);
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(PAUSE_FRAMES - 1);

    state_t             state_q, state_d;
    logic [3:0]         score_l_q, score_l_d, score_r_q, score_r_d;
    logic               serve_q, serve_d, serve_dir_q, serve_dir_d;
    logic               ball_hold_q, ball_hold_d, game_over_q, game_over_d;
    logic               winner_q, winner_d, armed_q, armed_d;
    logic [FRAME_W-1:0] cnt_q, cnt_d;
    logic               out_l_s_q, out_l_p_q, out_r_s_q, out_r_p_q;

    logic       goal_left_player, goal_right_player;
    logic [3:0] inc_l, inc_r;

    // Ball leaving the right edge credits the left player and vice versa.
    assign goal_left_player  = out_r_s_q & ~out_r_p_q;
    assign goal_right_player = out_l_s_q & ~out_l_p_q;
    assign inc_l             = score_l_q + 4'd1;
    assign inc_r             = score_r_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        serve_d     = 1'b0;
        serve_dir_d = serve_dir_q;
        ball_hold_d = ball_hold_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        armed_d     = armed_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                ball_hold_d = 1'b1;
                if (sk.start) begin
                    score_l_d   = 4'd0;
                    score_r_d   = 4'd0;
                    serve_d     = 1'b1;
                    serve_dir_d = 1'b0;
                    ball_hold_d = 1'b0;
                    state_d     = PLAY;
                end
            end
            PLAY: begin
                ball_hold_d = 1'b0;
                if (goal_left_player) begin
                    score_l_d   = inc_l;
                    ball_hold_d = 1'b1;
                    if (inc_l == WIN4) begin
                        winner_d    = 1'b0;
                        game_over_d = 1'b1;
                        armed_d     = 1'b0;
                        state_d     = GAME_OVER;
                    end else begin
                        serve_dir_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = PAUSE;
                    end
                end else if (goal_right_player) begin
                    score_r_d   = inc_r;
                    ball_hold_d = 1'b1;
                    if (inc_r == WIN4) begin
                        winner_d    = 1'b1;
                        game_over_d = 1'b1;
                        armed_d     = 1'b0;
                        state_d     = GAME_OVER;
                    end else begin
                        serve_dir_d = 1'b0;
                        cnt_d       = '0;
                        state_d     = PAUSE;
                    end
                end
            end
            PAUSE: begin
                ball_hold_d = 1'b1;
                if (sk.frame_tick) begin
                    if (cnt_q == LAST_FRAME) begin
                        serve_d     = 1'b1;
                        ball_hold_d = 1'b0;
                        state_d     = PLAY;
                    end else begin
                        cnt_d = cnt_q + FRAME_W'(1);
                    end
                end
            end
            GAME_OVER: begin
                ball_hold_d = 1'b1;
                game_over_d = 1'b1;
                // A button already held at match end must be released before it can restart.
                if (!sk.start) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    score_l_d   = 4'd0;
                    score_r_d   = 4'd0;
                    serve_d     = 1'b1;
                    serve_dir_d = 1'b0;
                    ball_hold_d = 1'b0;
                    game_over_d = 1'b0;
                    armed_d     = 1'b0;
                    state_d     = PLAY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            score_l_q   <= 4'd0;
            score_r_q   <= 4'd0;
            serve_q     <= 1'b0;
            serve_dir_q <= 1'b0;
            ball_hold_q <= 1'b1;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
            armed_q     <= 1'b0;
            cnt_q       <= '0;
            out_l_s_q   <= 1'b0;
            out_l_p_q   <= 1'b0;
            out_r_s_q   <= 1'b0;
            out_r_p_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            serve_q     <= serve_d;
            serve_dir_q <= serve_dir_d;
            ball_hold_q <= ball_hold_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
            out_l_s_q   <= sk.ball_out_left;
            out_l_p_q   <= out_l_s_q;
            out_r_s_q   <= sk.ball_out_right;
            out_r_p_q   <= out_r_s_q;
        end
    end

    assign sk.score_l   = score_l_q;
    assign sk.score_r   = score_r_q;
    assign sk.serve     = serve_q;
    assign sk.serve_dir = serve_dir_q;
    assign sk.ball_hold = ball_hold_q;
    assign sk.game_over = game_over_q;
    assign sk.winner    = winner_q;
endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - directed bench for score_keeper with a behavioural game model
module tb_score_keeper;
    localparam int WIN    = 9;
    localparam int FRAMES = 60;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    score_keeper_if sk_if ();

    score_keeper #(.WIN_SCORE(WIN), .PAUSE_FRAMES(FRAMES), .FRAME_W(6)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .sk      (sk_if)
    );

    always #5 clock = ~clock;

    // Game model: phase 0 idle, 1 play, 2 pause, 3 over
    int   m_phase, m_sl, m_sr, m_frames;
    bit   m_serve, m_dir, m_hold, m_go, m_win, m_armed;
    bit   seen_l [2];
    bit   seen_r [2];
    bit   pt_left, pt_right;

    task automatic new_match();
        m_sl = 0; m_sr = 0; m_serve = 1; m_dir = 0; m_hold = 0; m_go = 0;
        m_armed = 0; m_phase = 1;
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0; m_sl = 0; m_sr = 0; m_frames = 0;
            m_serve = 0; m_dir = 0; m_hold = 1; m_go = 0; m_win = 0; m_armed = 0;
            seen_l[0] = 0; seen_l[1] = 0; seen_r[0] = 0; seen_r[1] = 0;
        end else begin
            pt_left  = seen_r[0] && !seen_r[1];
            pt_right = seen_l[0] && !seen_l[1];
            m_serve  = 0;
            if (m_phase == 0) begin
                if (sk_if.start) new_match();
            end else if (m_phase == 1) begin
                if (pt_left || pt_right) begin
                    if (pt_left) m_sl = m_sl + 1; else m_sr = m_sr + 1;
                    m_hold = 1;
                    if (m_sl == WIN || m_sr == WIN) begin
                        m_win = (m_sr == WIN); m_go = 1; m_armed = 0; m_phase = 3;
                    end else begin
                        m_dir = pt_left; m_frames = 0; m_phase = 2;
                    end
                end
            end else if (m_phase == 2) begin
                if (sk_if.frame_tick) begin
                    m_frames = m_frames + 1;
                    if (m_frames == FRAMES) begin
                        m_serve = 1; m_hold = 0; m_phase = 1;
                    end
                end
            end else begin
                if (!sk_if.start) m_armed = 1;
                else if (m_armed) new_match();
            end
            seen_l[1] = seen_l[0]; seen_l[0] = sk_if.ball_out_left;
            seen_r[1] = seen_r[0]; seen_r[0] = sk_if.ball_out_right;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        check("model",
              {3'b0, sk_if.score_l, sk_if.score_r, sk_if.serve, sk_if.serve_dir,
               sk_if.ball_hold, sk_if.game_over, sk_if.winner},
              {3'b0, 4'(m_sl), 4'(m_sr), m_serve, m_dir, m_hold, m_go, m_win});
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic frame();
        sk_if.frame_tick = 1'b1;
        wait_clk(1);
        sk_if.frame_tick = 1'b0;
        wait_clk(2);
    endtask

    task automatic pulse_left();
        sk_if.ball_out_left = 1'b1;
        wait_clk(1);
        sk_if.ball_out_left = 1'b0;
    endtask

    initial begin
        sk_if.frame_tick = 0; sk_if.ball_out_left = 0; sk_if.ball_out_right = 0; sk_if.start = 0;
        wait_clk(3);
        check("rst_ball_hold", 16'(sk_if.ball_hold), 16'd1);
        check("rst_score_l", 16'(sk_if.score_l), 16'd0);
        reset_n = 1'b1;

        sk_if.start = 1'b1;
        wait_clk(1);
        check("start_serve", 16'(sk_if.serve), 16'd1);
        check("start_hold", 16'(sk_if.ball_hold), 16'd0);
        sk_if.start = 1'b0;
        wait_clk(1);
        check("serve_one_clk", 16'(sk_if.serve), 16'd0);

        sk_if.ball_out_right = 1'b1;
        wait_clk(1);
        check("score_l_lat1", 16'(sk_if.score_l), 16'd0);
        wait_clk(1);
        check("score_l_lat2", 16'(sk_if.score_l), 16'd1);
        wait_clk(48);
        sk_if.ball_out_right = 1'b0;
        check("score_l_once", 16'(sk_if.score_l), 16'd1);
        check("pause_hold", 16'(sk_if.ball_hold), 16'd1);

        for (int i = 0; i < FRAMES - 1; i++) begin
            if (i == 10) sk_if.ball_out_left = 1'b1;
            frame();
        end
        check("no_early_serve", 16'(sk_if.serve), 16'd0);
        sk_if.frame_tick = 1'b1;
        wait_clk(1);
        sk_if.frame_tick = 1'b0;
        check("reserve", 16'(sk_if.serve), 16'd1);
        check("reserve_dir", 16'(sk_if.serve_dir), 16'd1);
        wait_clk(3);
        sk_if.ball_out_left = 1'b0;
        wait_clk(3);
        check("pause_edge_dropped", 16'(sk_if.score_r), 16'd0);

        sk_if.ball_out_left = 1'b1; sk_if.ball_out_right = 1'b1;
        wait_clk(2);
        check("both_l", 16'(sk_if.score_l), 16'd2);
        check("both_r", 16'(sk_if.score_r), 16'd0);
        sk_if.ball_out_left = 1'b0; sk_if.ball_out_right = 1'b0;
        for (int i = 0; i < FRAMES; i++) frame();

        for (int g = 0; g < WIN - 1; g++) begin
            pulse_left();
            wait_clk(2);
            for (int i = 0; i < FRAMES; i++) frame();
        end
        check("score_r_8", 16'(sk_if.score_r), 16'd8);

        sk_if.start = 1'b1;
        pulse_left();
        wait_clk(2);
        check("win_score", 16'(sk_if.score_r), 16'd9);
        check("win_over", 16'(sk_if.game_over), 16'd1);
        check("win_who", 16'(sk_if.winner), 16'd1);
        sk_if.ball_out_right = 1'b1;
        wait_clk(1);
        sk_if.ball_out_right = 1'b0;
        wait_clk(3);
        check("over_frozen", 16'(sk_if.score_l), 16'd2);
        wait_clk(5);
        check("held_no_restart", 16'(sk_if.game_over), 16'd1);
        sk_if.start = 1'b0;
        wait_clk(2);
        sk_if.start = 1'b1;
        wait_clk(1);
        check("restart_serve", 16'(sk_if.serve), 16'd1);
        check("restart_over", 16'(sk_if.game_over), 16'd0);
        check("restart_scores", {sk_if.score_l, sk_if.score_r}, 16'd0);
        sk_if.start = 1'b0;

        sk_if.ball_out_right = 1'b1;
        wait_clk(1);
        sk_if.ball_out_right = 1'b0;
        wait_clk(2);
        for (int i = 0; i < 30; i++) frame();
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_outs",
              {3'b0, sk_if.score_l, sk_if.score_r, sk_if.serve, sk_if.serve_dir,
               sk_if.ball_hold, sk_if.game_over, sk_if.winner},
              16'b0000000000000100);
        wait_clk(2);
        reset_n = 1'b1;
        frame();
        check("idle_hold", 16'(sk_if.ball_hold), 16'd1);
        sk_if.start = 1'b1;
        wait_clk(1);
        check("idle_start", 16'(sk_if.serve), 16'd1);
        sk_if.start = 1'b0;
        wait_clk(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
